// File: rtl/phy_rx_frame.sv
// -----------------------------------------------------------------------------
// phy_rx_frame
//   RGMII receive framer. Takes the SDR byte stream produced by the RX IDDR
//   stage, strips preamble/SFD and forwards DA..FCS as an AXI-Stream master.
//   Errored (RX_ER), runt, oversize and (optionally) FCS-failing frames are
//   flagged with tuser on the tlast beat. There is no backpressure input: the
//   PHY cannot be stalled, so the downstream FIFO must always accept beats.
//
// Optional feature macro: PHY_RX_FCS_CHECK_EN
//   defined     -> CRC-32 checked over DA..FCS, bad residue sets tuser.
//   not defined -> no CRC logic; the downstream MAC checks the FCS.
//
// Ports
//   clk_125m       in   1      RX byte clock (recovered RXC)
//   sys_rst        in   1      synchronous active-high reset
//   rx_data        in   8      byte from IDDR
//   rx_ctl_r       in   1      RX_CTL rising sample  (= RX_DV)
//   rx_ctl_f       in   1      RX_CTL falling sample (= RX_DV ^ RX_ER)
//   m_axis_tdata   out  8      frame byte
//   m_axis_tvalid  out  1      byte valid (no gaps inside a frame)
//   m_axis_tlast   out  1      last byte of frame
//   m_axis_tuser   out  1      on tlast beat: 1 = bad frame
//   good_frames    out  CNT_W  frames ended with tuser=0 (wrapping)
//   bad_frames     out  CNT_W  frames ended with tuser=1 (wrapping)
// -----------------------------------------------------------------------------
module phy_rx_frame #(
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_125m,
  input  logic             sys_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_ctl_r,
  input  logic             rx_ctl_f,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic [CNT_W-1:0] good_frames,
  output logic [CNT_W-1:0] bad_frames
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_PAYLOAD  = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  localparam logic [15:0] MAX_LEN_L = 16'(MAX_LEN);
  localparam logic [15:0] MIN_LEN_L = 16'(MIN_LEN);

  // Stage S1: registered RGMII control/data
  logic [7:0]       r_s1_data;
  logic             r_s1_dv;
  logic             r_s1_er;

  // FSM and hold stage S2
  logic [1:0]       r_state;
  logic [7:0]       r_hold_data;
  logic             r_hold_vld;
  logic [15:0]      r_len;
  logic             r_err;
  logic [CNT_W-1:0] r_good;
  logic [CNT_W-1:0] r_bad;

  logic             w_emit;
  logic             w_at_max;
  logic             w_last;
  logic             w_oversize;
  logic             w_runt;
  logic             w_fcs_bad;
  logic             w_bad;
  logic             w_load;

  always_ff @(posedge clk_125m) begin
    if (sys_rst) begin
      r_s1_data <= 8'h00;
      r_s1_dv   <= 1'b0;
      r_s1_er   <= 1'b0;
    end else begin
      r_s1_data <= rx_data;
      r_s1_dv   <= rx_ctl_r;
      r_s1_er   <= rx_ctl_r & ~rx_ctl_f;
    end
  end

  // The held byte is emitted as soon as S1 shows what follows it: another
  // byte (plain beat) or dv low (tlast). Hitting MAX_LEN with more data
  // arriving closes the frame early as oversize.
  assign w_emit     = (r_state == ST_PAYLOAD) & r_hold_vld;
  assign w_at_max   = (r_len >= MAX_LEN_L);
  assign w_last     = w_emit & (~r_s1_dv | w_at_max);
  assign w_oversize = r_s1_dv & w_at_max;
  assign w_runt     = (r_len < MIN_LEN_L);
  assign w_load     = (r_state == ST_PAYLOAD) & r_s1_dv & ~(w_emit & w_at_max);

`ifdef PHY_RX_FCS_CHECK_EN
  logic [31:0] r_crc;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  // Running over DA..FCS leaves the fixed residue when the FCS is intact.
  always_ff @(posedge clk_125m) begin
    if (sys_rst) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (r_state != ST_PAYLOAD) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (w_load) begin
      r_crc <= crc32_byte(r_crc, r_s1_data);
    end
  end

  assign w_fcs_bad = (r_crc != 32'hDEBB_20E3);
`else
  assign w_fcs_bad = 1'b0;
`endif

  assign w_bad = r_err | w_runt | w_oversize | w_fcs_bad;

  always_ff @(posedge clk_125m) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_hold_data <= 8'h00;
      r_hold_vld  <= 1'b0;
      r_len       <= 16'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // er with dv outside a frame is carrier extension / false carrier
          if (r_s1_dv) begin
            r_state <= (r_s1_data == 8'h55) ? ST_PREAMBLE : ST_DROP;
          end
        end
        ST_PREAMBLE: begin
          if (!r_s1_dv) begin
            r_state <= ST_IDLE;
          end else if (r_s1_er) begin
            r_state <= ST_DROP;
          end else if (r_s1_data == 8'hD5) begin
            r_state    <= ST_PAYLOAD;
            r_len      <= 16'd0;
            r_err      <= 1'b0;
            r_hold_vld <= 1'b0;
          end else if (r_s1_data != 8'h55) begin
            r_state <= ST_DROP;
          end
        end
        ST_PAYLOAD: begin
          if (w_load) begin
            r_hold_data <= r_s1_data;
            r_hold_vld  <= 1'b1;
            r_len       <= (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
            r_err       <= r_err | r_s1_er;
          end
          if (w_last) begin
            r_hold_vld <= 1'b0;
            r_state    <= w_oversize ? ST_DROP : ST_IDLE;
          end else if (!r_s1_dv) begin
            // SFD immediately followed by dv low: empty frame, nothing out
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!r_s1_dv) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_125m) begin
    if (sys_rst) begin
      r_good <= '0;
      r_bad  <= '0;
    end else if (w_last) begin
      if (w_bad) begin
        r_bad <= r_bad + CNT_W'(1);
      end else begin
        r_good <= r_good + CNT_W'(1);
      end
    end
  end

  assign m_axis_tdata  = r_hold_data;
  assign m_axis_tvalid = w_emit;
  assign m_axis_tlast  = w_last;
  assign m_axis_tuser  = w_last & w_bad;
  assign good_frames   = r_good;
  assign bad_frames    = r_bad;

endmodule

// File: tb/tb_phy_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_phy_rx_frame
//   Drives whole RGMII frames (preamble, SFD, DA..FCS, idle gap) into
//   phy_rx_frame and compares the captured AXI-Stream beats and statistics
//   counters with a frame-level reference model (truncation, runt, RX_ER and
//   FCS rules applied to the transmitted byte list).
// -----------------------------------------------------------------------------
module tb_phy_rx_frame;
  localparam int MAX_LEN = 1522;
  localparam int MIN_LEN = 64;
  localparam int CNT_W   = 32;
`ifdef PHY_RX_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  logic             clk_125m = 1'b0;
  logic             sys_rst  = 1'b1;
  logic [7:0]       rx_data  = 8'h00;
  logic             rx_ctl_r = 1'b0;
  logic             rx_ctl_f = 1'b0;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tuser;
  logic [CNT_W-1:0] good_frames;
  logic [CNT_W-1:0] bad_frames;

  phy_rx_frame #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .CNT_W(CNT_W)) dut (
    .clk_125m      (clk_125m),
    .sys_rst       (sys_rst),
    .rx_data       (rx_data),
    .rx_ctl_r      (rx_ctl_r),
    .rx_ctl_f      (rx_ctl_f),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .good_frames   (good_frames),
    .bad_frames    (bad_frames)
  );

  always #4 clk_125m = ~clk_125m;

  int cyc = 0;
  always @(posedge clk_125m) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: capture every valid beat with the cycle it appeared in.
  logic [9:0] mon_q[$];
  int         mon_cyc[$];
  always @(negedge clk_125m) begin
    if (m_axis_tvalid === 1'b1) begin
      mon_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
      mon_cyc.push_back(cyc);
    end
  end

  // Reference model state
  logic [7:0] frame_q[$];
  int         good_cnt = 0;
  int         bad_cnt  = 0;

  // Ethernet FCS value (final complemented CRC-32) over frame_q[0..n-1].
  function automatic logic [31:0] ref_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frame_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Random DA..payload plus a correct FCS; optionally flip one payload bit.
  task automatic build_frame(input int n, input bit corrupt);
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < n - 4; i++) frame_q.push_back(8'($urandom));
    fcs = ref_fcs(n - 4);
    for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
    if (corrupt) frame_q[(n > 24) ? 20 : 0] ^= 8'h01;
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic f, input logic rst);
    @(posedge clk_125m);
    #1;
    rx_data  = d;
    rx_ctl_r = dv;
    rx_ctl_f = f;
    sys_rst  = rst;
  endtask

  // Send preamble (pre_len x 0x55), SFD (or a bad byte), frame_q and a
  // 12-cycle idle gap; then compare against the model.
  // er_idx  : frame byte carrying RX_ER (-1 = none)
  // rst_idx : frame byte during which sys_rst is pulsed (-1 = none)
  task automatic send_frame(input string tag, input int pre_len, input bit bad_pre,
                            input int er_idx, input int rst_idx);
    int         n;
    int         da_cyc;
    int         exp_n;
    int         got_n;
    bit         bad;
    bit         exp_last;
    logic [9:0] exp_w;
    logic [9:0] got_w;
    logic [31:0] fcs_rx;
    n      = frame_q.size();
    da_cyc = 0;
    mon_q.delete();
    mon_cyc.delete();
    for (int p = 0; p < pre_len; p++) drive(8'h55, 1'b1, 1'b1, 1'b0);
    drive(bad_pre ? 8'hAA : 8'hD5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(frame_q[i], 1'b1, (i == er_idx) ? 1'b0 : 1'b1, (i == rst_idx) ? 1'b1 : 1'b0);
      if (i == 0) da_cyc = cyc;
    end
    for (int g = 0; g < 12; g++) drive(8'h00, 1'b0, 1'b0, 1'b0);

    // Frame-level expectations
    fcs_rx = {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
    bad = (n < MIN_LEN) || (n > MAX_LEN) || (er_idx >= 0 && er_idx < n) ||
          (FCS_EN && (fcs_rx != ref_fcs(n - 4)));
    if (bad_pre)           exp_n = 0;
    else if (rst_idx >= 0) exp_n = rst_idx - 1;  // beats shown up to the reset edge
    else                   exp_n = (n > MAX_LEN) ? MAX_LEN : n;

    got_n = mon_q.size();
    check_eq({tag, ".beats"}, 64'(got_n), 64'(exp_n));
    for (int k = 0; k < got_n && k < exp_n; k++) begin
      exp_last = (rst_idx < 0) && (k == exp_n - 1);
      exp_w = {exp_last, exp_last & bad, frame_q[k]};
      got_w = {mon_q[k][9], mon_q[k][9] & mon_q[k][8], mon_q[k][7:0]};
      check_eq($sformatf("%s.beat%0d", tag, k), 64'(got_w), 64'(exp_w));
    end
    if (got_n > 0 && exp_n > 0) begin
      check_eq({tag, ".latency"}, 64'(mon_cyc[0] - da_cyc), 64'd2);
      check_eq({tag, ".nogap"}, 64'(mon_cyc[got_n-1] - mon_cyc[0]), 64'(got_n - 1));
    end

    if (rst_idx >= 0) begin
      good_cnt = 0;
      bad_cnt  = 0;
    end else if (exp_n > 0) begin
      if (bad) bad_cnt++;
      else     good_cnt++;
    end
    check_eq({tag, ".good_frames"}, 64'(good_frames), 64'(good_cnt));
    check_eq({tag, ".bad_frames"}, 64'(bad_frames), 64'(bad_cnt));
    $display("frame %s: len=%0d beats=%0d exp_beats=%0d bad=%0d good=%0d/%0d",
             tag, n, got_n, exp_n, bad, good_frames, bad_frames);
  endtask

  initial begin
    int n;
    int er;
    bit cor;

    repeat (5) @(posedge clk_125m);
    @(negedge clk_125m);
    check_eq("rst.tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst.tlast", 64'(m_axis_tlast), 64'd0);
    check_eq("rst.tuser", 64'(m_axis_tuser), 64'd0);
    check_eq("rst.tdata", 64'(m_axis_tdata), 64'd0);
    check_eq("rst.good", 64'(good_frames), 64'd0);
    check_eq("rst.bad", 64'(bad_frames), 64'd0);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(8'h00, 1'b0, 1'b0, 1'b0);

    build_frame(64, 1'b0);   send_frame("fcs_ok", 7, 1'b0, -1, -1);
    build_frame(64, 1'b1);   send_frame("fcs_flip", 7, 1'b0, -1, -1);
    build_frame(100, 1'b0);  send_frame("er_b20", 7, 1'b0, 19, -1);
    build_frame(40, 1'b0);   send_frame("runt40", 7, 1'b0, -1, -1);
    build_frame(1600, 1'b0); send_frame("oversize", 7, 1'b0, -1, -1);
    build_frame(1522, 1'b0); send_frame("maxlen", 7, 1'b0, -1, -1);
    build_frame(64, 1'b0);   send_frame("short_pre", 1, 1'b0, -1, -1);
    build_frame(64, 1'b0);   send_frame("bad_pre", 2, 1'b1, -1, -1);
    build_frame(64, 1'b0);   send_frame("after_bad_pre", 7, 1'b0, -1, -1);

    // Bytes masked so nothing after the reset can look like a preamble.
    build_frame(64, 1'b0);
    foreach (frame_q[i]) frame_q[i] &= 8'h3F;
    send_frame("mid_reset", 7, 1'b0, -1, 30);
    build_frame(64, 1'b0);   send_frame("after_reset", 7, 1'b0, -1, -1);

    for (int t = 0; t < 20; t++) begin
      n   = int'($urandom_range(30, 200));
      cor = ($urandom_range(0, 3) == 0);
      er  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      build_frame(n, cor);
      send_frame($sformatf("rand%0d", t), int'($urandom_range(1, 8)), 1'b0, er, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
